// File: rtl/l1s_pkg.sv
// Shared types and widths for the layer-1 streamer.
package l1s_pkg;

  localparam int DATA_W  = 13;
  localparam int ADDR_W  = 12;
  localparam int CSUM_W  = 16;
  localparam int ENTRY_W = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic last, input logic [DATA_W-1:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/l1s_fifo.sv
// Synchronous FIFO with data+last entries; head is presented combinationally from storage.
module l1s_fifo
  import l1s_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == (AW+1)'(0));
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  // a push at full is allowed when the same cycle frees the head slot
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/l1_streamer.sv
// Streams NPIX layer-1 pixels from memory to a ready/valid port through a credit-limited FIFO.
// Define L1S_CHECKSUM_EN to enable the running 16-bit pixel checksum.
module l1_streamer
  import l1s_pkg::*;
#(
  parameter int NPIX       = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              crd,
  output logic              csel,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic [CSUM_W-1:0] checksum
);

  localparam int NW  = ADDR_W + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 2;
  localparam logic [NW-1:0] LAST_N = NW'(NPIX - 1);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_crd;
  logic               r_crd_last;
  logic [ADDR_W-1:0]  r_addr;
  logic [NW-1:0]      r_n;
  logic               r_rd_vld;
  logic               r_rd_last;

  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [FCW-1:0]     w_count;
  logic               w_pop;
  logic [CW-1:0]      w_occ;
  logic               w_credit;
  logic               w_drained;

  l1s_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_rd_vld),
    .push_data (pack_entry(r_rd_last, cdata_rd)),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_last  = w_head[DATA_W];
  assign w_pop     = out_valid && out_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign crd       = r_crd;
  assign csel      = r_crd;
  assign caddr_rd  = r_addr;

  // buffered + in-flight entries after this edge must leave room for one more read
  assign w_occ     = CW'(w_count) + CW'(r_rd_vld) + CW'(r_crd);
  assign w_credit  = !w_full && (w_occ < (CW'(FIFO_DEPTH) + CW'(w_pop)));
  assign w_drained = !r_crd && !r_rd_vld && (CW'(w_count) == CW'(w_pop));

  // control FSM, read issue and read-return pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_crd_last <= 1'b0;
      r_addr     <= {ADDR_W{1'b0}};
      r_n        <= {NW{1'b0}};
      r_rd_vld   <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_vld  <= r_crd;
      r_rd_last <= r_crd_last;
      r_crd     <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // first read goes out with the start edge to meet the two-cycle latency
          if (start) begin
            r_busy     <= 1'b1;
            r_crd      <= 1'b1;
            r_crd_last <= (NPIX == 1);
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_n        <= NW'(1);
            r_state    <= (NPIX == 1) ? ST_DRAIN : ST_READ;
          end
        end
        ST_READ: begin
          if (w_credit) begin
            r_crd      <= 1'b1;
            r_crd_last <= (r_n == LAST_N);
            r_addr     <= ADDR_W'(BASE_ADDR) + r_n[ADDR_W-1:0];
            r_n        <= r_n + NW'(1);
            if (r_n == LAST_N) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef L1S_CHECKSUM_EN
  logic [CSUM_W-1:0] r_csum;

  // running sum of transferred pixels, cleared by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= {CSUM_W{1'b0}};
    end else if ((r_state == ST_IDLE) && start) begin
      r_csum <= {CSUM_W{1'b0}};
    end else if (w_pop) begin
      r_csum <= r_csum + CSUM_W'(out_data);
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = {CSUM_W{1'b0}};
`endif

endmodule

// File: tb/tb_l1_streamer.sv
// Scoreboard bench for l1_streamer: expected pixels queued at start, monitor compares each valid cycle.
module tb_l1_streamer;

  localparam int NPIX = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        crd;
  logic        csel;
  logic [11:0] caddr_rd;
  logic [12:0] cdata_rd;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic        out_last;
  logic        done;
  logic [15:0] checksum;

  logic [12:0] mem [4096];
  logic [13:0] exp_q [$];
  logic [15:0] exp_csum;
  logic        exp_done;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          rdy_mode = 0;

  l1_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .crd       (crd),
    .csel      (csel),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // memory model: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (crd && csel) cdata_rd <= mem[caddr_rd];
    else             cdata_rd <= 13'h1555;
  end

  // downstream ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: compare head against scoreboard on every valid cycle, check done timing
  initial begin
    exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_done = 1'b0;
      end else begin
        if (done || exp_done) begin
          chk("done_pulse", int'(done), int'(exp_done));
          if (done) begin
            done_cnt++;
            chk("checksum_at_done", int'(checksum), int'(exp_csum));
          end
        end
        exp_done = 1'b0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(out_data), -1);
          end else begin
            chk("out_data", int'(out_data), int'(exp_q[0][12:0]));
            chk("out_last", int'(out_last), int'(exp_q[0][13]));
            if (out_ready) begin
              if (exp_q[0][13]) exp_done = 1'b1;
              void'(exp_q.pop_front());
              xfer_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic load_frame();
    logic [15:0] sum;
    sum = 16'h0000;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back({(i == NPIX - 1), mem[i]});
      sum = sum + 16'(mem[i]);
    end
`ifdef L1S_CHECKSUM_EN
    exp_csum = sum;
`else
    exp_csum = 16'h0000;
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int cyc;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #3;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_crd"}, int'(crd), 0);
    chk({tag, "_csel"}, int'(csel), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int d0;
    int x0;
    int nrd;
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    exp_csum = 16'h0000;
    for (int i = 0; i < 4096; i++) mem[i] = 13'(i);

    // reset values
    #3;
    check_idle_outputs("rst");
    chk("rst_caddr", int'(caddr_rd), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_checksum", int'(checksum), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // frame 1: mem[i]=i, always ready, latency check
    load_frame();
`ifdef L1S_CHECKSUM_EN
    chk("csum_model_fe00", int'(exp_csum), 16'hFE00);
`endif
    d0 = done_cnt;
    x0 = xfer_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    #2;
    chk("lat_c1_busy", int'(busy), 1);
    chk("lat_c1_crd", int'(crd), 1);
    chk("lat_c1_csel", int'(csel), 1);
    chk("lat_c1_caddr", int'(caddr_rd), 0);
    chk("lat_c1_valid", int'(out_valid), 0);
    @(posedge clk); #3;
    chk("lat_c2_valid", int'(out_valid), 0);
    chk("lat_c2_caddr", int'(caddr_rd), 1);
    @(posedge clk); #3;
    chk("lat_c3_valid", int'(out_valid), 1);
    wait_done(d0, 3000);
    chk("f1_xfers", xfer_cnt - x0, NPIX);
    chk("f1_queue_empty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #3;
    chk("f1_checksum_hold", int'(checksum), int'(exp_csum));
    check_idle_outputs("f1_idle");

    // frame 2: ready stalls 1-in-3, new memory pattern
    for (int i = 0; i < 4096; i++) mem[i] = 13'((i * 37 + 5) % 8192);
    load_frame();
    rdy_mode = 1;
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    wait_done(d0, 6000);
    chk("f2_xfers", xfer_cnt - x0, NPIX);
    chk("f2_queue_empty", exp_q.size(), 0);

    // frame 3: ready low for 20 cycles, read issue must stop at the buffer depth
    for (int i = 0; i < 4096; i++) mem[i] = 13'(i);
    load_frame();
    @(posedge clk); #1 rdy_mode = 2;
    d0 = done_cnt;
    x0 = xfer_cnt;
    nrd = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (crd) nrd++;
      @(posedge clk); #1;
    end
    chk("stall_reads_issued", nrd, 4);
    chk("stall_crd_low", int'(crd), 0);
    chk("stall_no_xfer", xfer_cnt - x0, 0);
    rdy_mode = 0;
    wait_done(d0, 3000);
    chk("f3_xfers", xfer_cnt - x0, NPIX);

    // frame 4: reset at transfer 500, then restream from address 0
    load_frame();
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    cyc = 0;
    while (xfer_cnt - x0 < 500 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    chk("f4_reached_500", int'(xfer_cnt - x0 >= 500), 1);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_caddr", int'(caddr_rd), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_out_last", int'(out_last), 0);
    chk("midrst_checksum", int'(checksum), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    load_frame();
    d0 = done_cnt;
    x0 = xfer_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    #2;
    chk("restart_caddr", int'(caddr_rd), 0);
    wait_done(d0, 3000);
    chk("f4_xfers", xfer_cnt - x0, NPIX);

    // frame 5: second start while busy is ignored
    load_frame();
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    x0 = xfer_cnt;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    wait_done(d0, 3000);
    repeat (40) @(posedge clk);
    #3;
    chk("dbl_start_done_cnt", done_cnt - d0, 1);
    chk("dbl_start_xfers", xfer_cnt - x0, NPIX);
    chk("dbl_start_queue", exp_q.size(), 0);
    check_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
